// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one byte-lane memory between the
// instruction side (read-only) and the data side (read/write).
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data_in  [4],
    input  logic [7:0]        mem_data_out [4]
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;    // 0 = I side, 1 = D side
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              gnt;
    logic [31:0]       rd_word;

    assign rd_word = {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        gnt       = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the side that did not win last time goes first.
                    gnt     = (i_req && d_req) ? ~last_q : d_req;
                    owner_d = gnt;
                    last_d  = gnt;
                    addr_d  = gnt ? d_addr : i_addr;
                    we_d    = gnt & d_we;
                    wdata_d = gnt ? d_wdata : 32'h0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    if (!we_q) begin
                        if (owner_q) d_rdata_d = rd_word;
                        else         i_rdata_d = rd_word;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory side is driven only from latched fields, so it holds outside BUSY.
    assign mem_req        = (state_q == BUSY);
    assign mem_write_en   = mem_req & we_q;
    assign mem_addr       = addr_q;
    assign mem_data_in[0] = wdata_q[31:24];
    assign mem_data_in[1] = wdata_q[23:16];
    assign mem_data_in[2] = wdata_q[15:8];
    assign mem_data_in[3] = wdata_q[7:0];

    assign i_ready = (state_q == RESP) && !owner_q;
    assign d_ready = (state_q == RESP) &&  owner_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LATENCY=4 instance and a MEM_LATENCY=1 instance.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: fixed word at 0x1000, otherwise address XOR pattern.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h0000_1000) ? 32'h1234_5678 : (a ^ 32'hA5A5_5A5A);
    endfunction

    // ---------------- MEM_LATENCY = 4 instance ----------------
    logic        reset, i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ready, d_ready, mem_req, mem_write_en;
    logic [31:0] i_rdata, d_rdata, mem_addr;
    logic [7:0]  mem_data_in [4];
    logic [7:0]  mem_data_out [4];
    logic [31:0] mdi, mword;

    always_comb begin
        mword = memf(mem_addr);
        mem_data_out[0] = mword[31:24];
        mem_data_out[1] = mword[23:16];
        mem_data_out[2] = mword[15:8];
        mem_data_out[3] = mword[7:0];
        mdi = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
    end

    mem_arbiter #(.MEM_LATENCY(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // ---------------- MEM_LATENCY = 1 instance ----------------
    logic        reset1, i_req1;
    logic [31:0] i_addr1;
    logic        i_ready1, d_ready1, mem_req1, mem_write_en1;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mword1;
    logic [7:0]  mem_data_in1 [4];
    logic [7:0]  mem_data_out1 [4];

    always_comb begin
        mword1 = memf(mem_addr1);
        mem_data_out1[0] = mword1[31:24];
        mem_data_out1[1] = mword1[23:16];
        mem_data_out1[2] = mword1[15:8];
        mem_data_out1[3] = mword1[7:0];
    end

    mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) dut1 (
        .clk(clk), .reset(reset1),
        .i_req(i_req1), .i_addr(i_addr1), .i_ready(i_ready1), .i_rdata(i_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ready(d_ready1), .d_rdata(d_rdata1),
        .mem_req(mem_req1), .mem_write_en(mem_write_en1), .mem_addr(mem_addr1),
        .mem_data_in(mem_data_in1), .mem_data_out(mem_data_out1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in the cycle before the grant edge; returns in the IDLE cycle after RESP.
    task automatic txn(input string tag, input bit side_d, input logic [31:0] exp_addr,
                       input logic [31:0] exp_rd);
        tick();
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        repeat (3) tick();
        chk({tag, "_busy_end"}, 32'(mem_req), 32'd1);
        tick();
        chk({tag, "_d_ready"}, 32'(d_ready), 32'(side_d));
        chk({tag, "_i_ready"}, 32'(i_ready), 32'(!side_d));
        chk({tag, "_rdata"}, side_d ? d_rdata : i_rdata, exp_rd);
        tick();
        chk({tag, "_idle_req"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        reset1 = 1'b1; i_req1 = 1'b0; i_addr1 = '0;
        tick(); tick();

        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_write_en), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_data", mdi, 32'h0);
        chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'h0);
        reset = 1'b0;

        // D write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("wr_req", 32'(mem_req), 32'd1);
            chk("wr_we", 32'(mem_write_en), 32'd1);
            chk("wr_addr", mem_addr, 32'h40);
            chk("wr_data", mdi, 32'hDEAD_BEEF);
            chk("wr_no_ready", 32'(d_ready), 32'd0);
            tick();
        end
        chk("wr_d_ready", 32'(d_ready), 32'd1);
        chk("wr_i_ready", 32'(i_ready), 32'd0);
        chk("wr_resp_req", 32'(mem_req), 32'd0);
        chk("wr_resp_we", 32'(mem_write_en), 32'd0);
        chk("wr_d_rdata", d_rdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("wr_ready_once", 32'(d_ready), 32'd0);
        chk("wr_addr_hold", mem_addr, 32'h40);

        // I read
        i_req = 1'b1; i_addr = 32'h1000;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("rd_req", 32'(mem_req), 32'd1);
            chk("rd_we", 32'(mem_write_en), 32'd0);
            tick();
        end
        chk("rd_i_ready", 32'(i_ready), 32'd1);
        chk("rd_i_rdata", i_rdata, 32'h1234_5678);
        chk("rd_d_ready", 32'(d_ready), 32'd0);
        i_req = 1'b0;
        tick();
        chk("rd_ready_once", 32'(i_ready), 32'd0);
        chk("rd_rdata_hold", i_rdata, 32'h1234_5678);

        // Tie after reset: D, I, D, I
        reset = 1'b1; tick(); reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h2000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        txn("tie1_D", 1'b1, 32'h3000, 32'hA5A5_6A5A);
        txn("tie2_I", 1'b0, 32'h2000, 32'hA5A5_7A5A);
        txn("tie3_D", 1'b1, 32'h3000, 32'hA5A5_6A5A);
        txn("tie4_I", 1'b0, 32'h2000, 32'hA5A5_7A5A);
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // Requester fields change mid-BUSY
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1122_3344;
        tick(); tick();
        d_addr = 32'hFFFF_FFFF; d_wdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            chk("mid_addr", mem_addr, 32'h80);
            chk("mid_data", mdi, 32'h1122_3344);
            tick();
        end
        chk("mid_d_ready", 32'(d_ready), 32'd1);
        chk("mid_addr_resp", mem_addr, 32'h80);
        d_req = 1'b0; d_we = 1'b0;
        tick();

        // Reset in BUSY cycle 2 of a D read (last becomes D before reset)
        d_req = 1'b1; d_addr = 32'h3000;
        tick(); tick();
        chk("ab_busy", 32'(mem_req), 32'd1);
        reset = 1'b1; #1;
        chk("ab_req", 32'(mem_req), 32'd0);
        chk("ab_addr", mem_addr, 32'h0);
        chk("ab_data", mdi, 32'h0);
        chk("ab_rdata", i_rdata | d_rdata, 32'h0);
        d_req = 1'b0;
        tick(); reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("ab_no_ready", {30'd0, i_ready, d_ready}, 32'd0);
            tick();
        end
        i_req = 1'b1; i_addr = 32'h2000;
        d_req = 1'b1; d_addr = 32'h3000;
        txn("ab_tie_D", 1'b1, 32'h3000, 32'hA5A5_6A5A);
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // MEM_LATENCY = 1: single I read
        reset1 = 1'b0;
        i_req1 = 1'b1; i_addr1 = 32'h1000;
        tick();
        chk("l1_busy_req", 32'(mem_req1), 32'd1);
        chk("l1_busy_ready", 32'(i_ready1), 32'd0);
        tick();
        chk("l1_resp_req", 32'(mem_req1), 32'd0);
        chk("l1_i_ready", 32'(i_ready1), 32'd1);
        chk("l1_i_rdata", i_rdata1, 32'h1234_5678);
        i_req1 = 1'b0;
        tick();
        chk("l1_ready_once", 32'(i_ready1), 32'd0);
        chk("l1_idle_req", 32'(mem_req1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
